// File: rtl/demux_pkg.sv
// Shared select encodings and the one-hot helper used by the 1-to-4 demux.
package demux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_Y0 = 2'b00;
    localparam sel_t SEL_Y1 = 2'b01;
    localparam sel_t SEL_Y2 = 2'b10;
    localparam sel_t SEL_Y3 = 2'b11;

    function automatic logic [3:0] onehot4(input sel_t sel);
        logic [3:0] oh;
        oh = 4'b0000;
        case (sel)
            SEL_Y0:  oh = 4'b0001;
            SEL_Y1:  oh = 4'b0010;
            SEL_Y2:  oh = 4'b0100;
            SEL_Y3:  oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/demux_sel_decode.sv
// Combinational 2-to-4 one-hot decoder; all outputs low when disabled.
module demux_sel_decode
    import demux_pkg::*;
(
    input  sel_t       sel,
    input  logic       en,
    output logic [3:0] dec
);

    always_comb begin
        dec = 4'b0000;
        if (en) begin
            dec = onehot4(sel);
        end
    end

endmodule

// File: rtl/demux_4x1.sv
// Registered 1-to-4 demultiplexer: d is steered to one of y0..y3, the rest
// are held at zero; route/out_valid describe the sample on the outputs.
module demux_4x1
    import demux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             s0,
    input  logic             s1,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       route,
    output logic             out_valid
);

    sel_t             sel;
    logic [3:0]       dec;
    logic [WIDTH-1:0] y0_d, y1_d, y2_d, y3_d;
    logic [WIDTH-1:0] y0_q, y1_q, y2_q, y3_q;
    logic [3:0]       route_q;
    logic             valid_q;

    assign sel = {s1, s0};

    demux_sel_decode u_dec (
        .sel (sel),
        .en  (en),
        .dec (dec)
    );

    // Each decode bit masks d, so unselected outputs are forced to zero.
    always_comb begin
        y0_d = d & {WIDTH{dec[0]}};
        y1_d = d & {WIDTH{dec[1]}};
        y2_d = d & {WIDTH{dec[2]}};
        y3_d = d & {WIDTH{dec[3]}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y0_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            y3_q    <= '0;
            route_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            y3_q    <= y3_d;
            route_q <= dec;
            valid_q <= en;
        end
    end

    assign y0        = y0_q;
    assign y1        = y1_q;
    assign y2        = y2_q;
    assign y3        = y3_q;
    assign route     = route_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_demux_4x1.sv
// Self-checking bench for demux_4x1 (WIDTH=8): directed scenarios plus random
// traffic compared against an array-based reference model.
module tb_demux_4x1;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         s0;
    logic         s1;
    logic [W-1:0] d;
    logic [W-1:0] y0, y1, y2, y3;
    logic [3:0]   route;
    logic         out_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what each output must show after the edge.
    logic [W-1:0] m_y [4];
    logic [3:0]   m_route;
    logic         m_valid;

    demux_4x1 #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .s0        (s0),
        .s1        (s1),
        .d         (d),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .route     (route),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    a_route_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(route));
    a_y_implies_route: assert property (@(negedge clk)
        ((y0 == '0) || route[0]) && ((y1 == '0) || route[1]) &&
        ((y2 == '0) || route[2]) && ((y3 == '0) || route[3]));
    a_reset_held: assert property (@(posedge clk) !rst_n |->
        (y0 == '0 && y1 == '0 && y2 == '0 && y3 == '0 && route == 4'b0000 && !out_valid));
    a_sel_known: assert property (@(posedge clk) disable iff (!rst_n) en |-> !$isunknown({s1, s0}));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Model: the selected index receives d, every other output is zero.
    task automatic model_update(input logic m_en, input int sel, input logic [W-1:0] m_d);
        for (int k = 0; k < 4; k++) begin
            m_y[k] = (m_en && sel == k) ? m_d : '0;
        end
        m_route = m_en ? 4'(1 << sel) : 4'b0000;
        m_valid = m_en;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) m_y[k] = '0;
        m_route = 4'b0000;
        m_valid = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_y0"}, 32'(y0), 32'(m_y[0]));
        check({tag, "_y1"}, 32'(y1), 32'(m_y[1]));
        check({tag, "_y2"}, 32'(y2), 32'(m_y[2]));
        check({tag, "_y3"}, 32'(y3), 32'(m_y[3]));
        check({tag, "_route"}, 32'(route), 32'(m_route));
        check({tag, "_valid"}, 32'(out_valid), 32'(m_valid));
    endtask

    // Apply inputs on the falling edge, then check one edge later.
    task automatic drive(input logic t_en, input int sel, input logic [W-1:0] t_d, input string tag);
        @(negedge clk);
        en = t_en;
        s1 = 1'((sel >> 1) & 1);
        s0 = 1'(sel & 1);
        d  = t_d;
        @(posedge clk);
        model_update(t_en, sel, t_d);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        s0    = 1'b1;
        s1    = 1'b1;
        d     = 8'h01;
        model_clear();

        // Reset held with active-looking inputs.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_outputs("reset");
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Select sweep with d=1.
        for (int s = 0; s < 4; s++) drive(1'b1, s, 8'h01, "sweep");

        // Zero data: outputs stay zero, route still tracks.
        for (int s = 0; s < 4; s++) drive(1'b1, s, 8'h00, "zero");

        // Enable gating on sel=10.
        drive(1'b1, 2, 8'h01, "en_on");
        drive(1'b0, 2, 8'h01, "en_off");
        drive(1'b1, 2, 8'h01, "en_back");

        // Async reset between edges while y1 is active.
        drive(1'b1, 1, 8'h01, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_outputs("async_rst");
        rst_n = 1'b1;
        drive(1'b1, 1, 8'h01, "post_rst");

        // Full-width pattern.
        drive(1'b1, 3, 8'hA5, "width");
        drive(1'b1, 0, 8'hFF, "width_ff");

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                  W'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/demux_4x1.md
# demux_4x1

Registered 1-to-4 demultiplexer. Routes data input `d` to exactly one of four outputs `y0`–`y3`, selected by the 2-bit select `{s1, s0}`. All unselected outputs are driven to zero. It is a leaf routing block used wherever a single source must be steered to one of four sinks. Outputs are registered on `clk` with one cycle of latency.

## Interface
Parameters:
- `WIDTH`, default 1, bit width of `d` and of each `y*` output.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset; assertion is immediate, release is synchronous to `clk` (synchronised upstream).
- `en`  input  1  route enable; when low, all data outputs are zeroed on the next edge.
- `s0`  input  1  select LSB.
- `s1`  input  1  select MSB.
- `d`  input  WIDTH  data to route.
- `y0`  output  WIDTH  `d` when `{s1,s0}`=00, else 0.
- `y1`  output  WIDTH  `d` when `{s1,s0}`=01 (s0=1, s1=0), else 0.
- `y2`  output  WIDTH  `d` when `{s1,s0}`=10 (s0=0, s1=1), else 0.
- `y3`  output  WIDTH  `d` when `{s1,s0}`=11, else 0.
- `route`  output  4  one-hot registered copy of the active selection; bit i is set when `yi` is selected and `en`=1; 0000 when disabled.
- `out_valid`  output  1  registered `en`; marks the cycle in which `y*` and `route` reflect a routed sample.

## Operation
- Select index: `sel = {s1, s0}`. `s1` is the MSB.
- Every rising edge with `rst_n`=1:
  - If `en`=1: `y[sel] <= d`, every other `y* <= 0`, `route <= onehot(sel)`, `out_valid <= 1`.
  - If `en`=0: all `y* <= 0`, `route <= 4'b0000`, `out_valid <= 0`.
- Invariant: at most one `y*` is non-zero, and `route` is always one-hot or zero.
- A non-selected output is 0 even when `d`=0. A selected output carries `d` bit-exact across all WIDTH bits.
- No X propagation: an X/Z on `s0` or `s1` is a test error. The design has no defined behaviour for it. Verification asserts that the selects are known whenever `en`=1.

## Timing
- Reset (`rst_n`=0): `y0`–`y3` = 0, `route` = 0000 and `out_valid` = 0, immediately and independent of `clk`.
- Latency: 1 clock from `d`/`s0`/`s1`/`en` sampled at edge N to outputs valid after edge N.
- Select change: takes effect at the next edge. The previously selected output returns to 0 on that same edge. There is no cycle with two outputs active and no cycle with a gap.
- Reset asserted mid-stream: outputs clear asynchronously. The first sample after release is the first edge with `rst_n`=1.
- Data and select may change every cycle; throughput is one sample per clock. There is no handshake or backpressure.

## Structure
- Shared package `demux_pkg`:
  - `SEL_Y0`=2'b00, `SEL_Y1`=2'b01, `SEL_Y2`=2'b10, `SEL_Y3`=2'b11.
  - `sel_t` typedef (2-bit).
  - `onehot4(sel)` function.
- Sub-module `demux_sel_decode`: combinational 2-to-4 one-hot decoder with enable. Inputs `sel`, `en`; output `dec[3:0]`.
- Top level:
  - Gates `d` with each `dec` bit to form next-state `y*`.
  - Registers `y*`, `route` and `out_valid` in a single async-reset always block.
- SVA, bound from the verification side:
  - one-hot-or-zero on `route`;
  - `yi != 0` implies `route[i]`;
  - reset values are held.

## Test plan
- Reset: hold `rst_n`=0 with `d`=1, `en`=1, sel=11 for 3 clocks. Expect `y0`–`y3`=0, `route`=0000, `out_valid`=0 throughout.
- Select sweep with `d`=1, `en`=1, sel stepped 00→01→10→11 one per clock. One cycle after each step:
  - expect y0=1 only, then y1=1 only, then y2=1 only, then y3=1 only;
  - `route` follows: 0001→0010→0100→1000.
- Zero data: `d`=0, `en`=1, each sel. Expect all `y*`=0 while `route` still tracks sel and `out_valid`=1.
- Enable gating: sel=10, `d`=1, toggle `en` 1→0→1. Expect y2=1, then all zero with `route`=0000 and `out_valid`=0, then y2=1 again, each one clock after the change.
- Async reset mid-stream: while sel=01 and y1=1, pulse `rst_n` low between clock edges. Expect y1 to drop to 0 immediately, and routing to resume one edge after release.
- Width (WIDTH=8): `d`=8'hA5, sel=11. Expect y3=8'hA5 and y0–y2=8'h00.
